// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches, buffers responses
// in a 2-entry prefetch FIFO and presents the head {pc, instr} to IF/ID.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  // state     | meaning
  // S_FETCH   | no request outstanding; request when FIFO has room
  // S_WAIT    | one request outstanding; its response is pushed
  // S_DISCARD | one request outstanding; its response is dropped (flushed)
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DISCARD} state_t;

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  state_t      state;
  logic        run_q;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [1:0]  count;
  logic [31:0] head_pc, head_instr;
  logic [31:0] tail_pc, tail_instr;

  logic grant;
  logic push;
  logic pop;
  logic unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  // run_q holds the first request off until the first edge after reset release
  assign imem_req_o  = run_q && (state == S_FETCH) && (count < DEPTH) && !redirect_i;
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o && imem_gnt_i;
  assign push        = (state == S_WAIT) && imem_rvalid_i && !redirect_i;
  assign pop         = valid_o && !stall_i && !redirect_i;

  assign valid_o = (count != 2'd0);
  assign instr_o = valid_o ? head_instr : 32'h0;
  assign pc_o    = valid_o ? head_pc    : 32'h0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_FETCH;
      run_q    <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc   <= 32'h0;
    end else begin
      run_q <= 1'b1;
      if (redirect_i) begin
        fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        case (state)
          S_WAIT, S_DISCARD: state <= imem_rvalid_i ? S_FETCH : S_DISCARD;
          default:           state <= S_FETCH;
        endcase
      end else begin
        case (state)
          S_FETCH: begin
            if (grant) begin
              req_pc   <= fetch_pc;
              fetch_pc <= fetch_pc + 32'd4;
              state    <= S_WAIT;
            end
          end
          S_WAIT, S_DISCARD: begin
            if (imem_rvalid_i) state <= S_FETCH;
          end
          default: state <= S_FETCH;
        endcase
      end
    end
  end

  // Shift-style FIFO: head is always entry 0, so outputs need no read pointer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count      <= 2'd0;
      head_pc    <= 32'h0;
      head_instr <= 32'h0;
      tail_pc    <= 32'h0;
      tail_instr <= 32'h0;
    end else if (redirect_i) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc    <= req_pc;
            head_instr <= imem_rdata_i;
          end else begin
            tail_pc    <= req_pc;
            tail_instr <= imem_rdata_i;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc    <= tail_pc;
          head_instr <= tail_instr;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc    <= req_pc;
            head_instr <= imem_rdata_i;
          end else begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            tail_pc    <= req_pc;
            tail_instr <= imem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: consumed {pc, instr} pairs are checked
// against a scoreboard queue; fetch addresses and timing are checked inline.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int pend_cnt;
  logic [31:0] pend_addr;
  logic [63:0] exp_q[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .valid_o       (valid),
    .instr_o       (instr),
    .pc_o          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: response arrives lat cycles after grant; data = ~address
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt  <= 0;
      pend_addr <= 32'h0;
    end else if (imem_req && imem_gnt) begin
      pend_cnt  <= lat;
      pend_addr <= imem_addr;
    end else if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end
  assign imem_rvalid = (pend_cnt == 1);
  assign imem_rdata  = ~pend_addr;

  // Monitor: compare every consumed head against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (imem_req && pend_cnt != 0) begin
        bad++;
        $display("FAIL outstanding: req=%0b while pending=%0d, required no request", imem_req, pend_cnt);
      end
      if (valid && !stall && !redirect) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL consume: got pc=%h instr=%h, required nothing consumed", pc, instr);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if ({pc, instr} !== e) begin
            bad++;
            $display("FAIL consume: got pc=%h instr=%h, required pc=%h instr=%h",
                     pc, instr, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_q.push_back({p, ~p});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b1; lat = 1;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h100);

    // Sequential fetch after reset release
    cyc(); rst_n = 1'b1;
    expect_pc(32'h100); expect_pc(32'h104);
    cyc();  @(negedge clk);
    chk("c1_req", 32'(imem_req), 32'h1); chk("c1_addr", imem_addr, 32'h100); chk("c1_valid", 32'(valid), 32'h0);
    cyc();  @(negedge clk);
    chk("c2_valid", 32'(valid), 32'h0); chk("c2_req", 32'(imem_req), 32'h0);
    cyc();  @(negedge clk);
    chk("c3_valid", 32'(valid), 32'h1); chk("c3_pc", pc, 32'h100); chk("c3_addr", imem_addr, 32'h104);
    cyc();  @(negedge clk);
    chk("c4_valid", 32'(valid), 32'h0);
    cyc();  @(negedge clk);
    chk("c5_pc", pc, 32'h104); chk("c5_addr", imem_addr, 32'h108); chk("c5_req", 32'(imem_req), 32'h1);
    cyc();  @(negedge clk);
    chk("c6_req", 32'(imem_req), 32'h0); chk("c6_valid", 32'(valid), 32'h0);

    // Asynchronous reset while the 0x108 fetch is outstanding
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_pc", pc, 32'h0);

    // Stall fills the FIFO, then releases in order
    cyc();
    cyc(); rst_n = 1'b1;
    expect_pc(32'h100);
    cyc(); cyc();
    cyc(); stall = 1'b1; @(negedge clk);
    chk("s3_pc", pc, 32'h100);
    cyc(); @(negedge clk);
    chk("s4_pc", pc, 32'h100);
    for (int k = 5; k <= 8; k++) begin
      cyc(); @(negedge clk);
      chk("stall_req", 32'(imem_req), 32'h0);
      chk("stall_pc", pc, 32'h100);
    end
    cyc(); stall = 1'b0; @(negedge clk);
    chk("s9_pc", pc, 32'h100); chk("s9_req", 32'(imem_req), 32'h0);
    cyc(); stall = 1'b1; lat = 3; @(negedge clk);
    chk("s10_pc", pc, 32'h104); chk("s10_req", 32'(imem_req), 32'h1); chk("s10_addr", imem_addr, 32'h108);

    // Redirect under stall while 0x108 is outstanding; its data must be dropped
    cyc(); redirect = 1'b1; redirect_pc = 32'h203; @(negedge clk);
    chk("rd_req", 32'(imem_req), 32'h0); chk("rd_valid", 32'(valid), 32'h1);
    cyc(); redirect = 1'b0; stall = 1'b0; lat = 1; @(negedge clk);
    chk("fl_valid", 32'(valid), 32'h0); chk("fl_instr", instr, 32'h0); chk("fl_pc", pc, 32'h0);
    chk("disc_req", 32'(imem_req), 32'h0);
    cyc(); @(negedge clk);
    chk("disc_rv_valid", 32'(valid), 32'h0); chk("disc_rv_req", 32'(imem_req), 32'h0);
    cyc(); expect_pc(32'h200); @(negedge clk);
    chk("tgt_req", 32'(imem_req), 32'h1); chk("tgt_addr", imem_addr, 32'h200);
    cyc(); cyc(); @(negedge clk);
    chk("tgt_pc", pc, 32'h200);

    // Redirect coinciding with rvalid in WAIT; then grant withheld 3 cycles
    cyc(); redirect = 1'b1; redirect_pc = 32'h300; imem_gnt = 1'b0; @(negedge clk);
    chk("rvr_valid", 32'(valid), 32'h0);
    for (int k = 18; k <= 20; k++) begin
      cyc(); redirect = 1'b0; @(negedge clk);
      chk("hold_req", 32'(imem_req), 32'h1);
      chk("hold_addr", imem_addr, 32'h300);
      chk("hold_valid", 32'(valid), 32'h0);
    end
    cyc(); imem_gnt = 1'b1; @(negedge clk);
    chk("gnt_addr", imem_addr, 32'h300);
    cyc(); @(negedge clk);
    chk("post_gnt_addr", imem_addr, 32'h304); chk("post_gnt_req", 32'(imem_req), 32'h0);

    // Redirect flushes 0x300 and targets the top word to exercise wrap
    cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; @(negedge clk);
    chk("w_pc300", pc, 32'h300); chk("w_instr300", instr, ~32'h300);
    cyc(); redirect = 1'b0; expect_pc(32'hFFFF_FFFC); expect_pc(32'h0); @(negedge clk);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC); chk("wrap_req", 32'(imem_req), 32'h1);
    cyc(); @(negedge clk);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    cyc(); @(negedge clk);
    chk("wrap_pc", pc, 32'hFFFF_FFFC); chk("wrap_instr", instr, 32'h0000_0003);
    cyc(); cyc(); @(negedge clk);
    chk("wrap_pc0", pc, 32'h0);
    cyc(); stall = 1'b1;
    repeat (4) cyc();
    chk("scoreboard_left", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch-side producer that feeds the IF/ID pipeline register. It drives sequential PCs to the instruction memory over a request/grant/response handshake and buffers returned words in a 2-entry prefetch FIFO. It presents {pc, instr} to IF/ID, honours the same stall the IF/ID register sees, and discards the FIFO and any in-flight fetch on a branch redirect. An empty FIFO yields a NOP bubble of 32'b0.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
FIFO_DEPTH, 2, prefetch entries; fixed at 2, no other value is supported.

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  asynchronous active-low reset.
stall_i  in  1  IF/ID stall; head entry is not consumed while high.
redirect_i  in  1  branch/jump taken; flush and refetch.
redirect_pc_i  in  32  redirect target; bits [1:0] are ignored and forced to 0.
imem_req_o  out  1  fetch request.
imem_addr_o  out  32  fetch address, word aligned.
imem_gnt_i  in  1  request accepted this cycle when high together with imem_req_o.
imem_rvalid_i  in  1  response valid, at least 1 cycle after grant.
imem_rdata_i  in  32  response instruction word.
valid_o  out  1  FIFO head is valid.
instr_o  out  32  head instruction; 32'b0 when empty.
pc_o  out  32  head PC; 32'b0 when empty.

Behaviour:
- Reset, while rst_n_i is low:
  - fetch_pc = RESET_PC; FIFO empty; state FETCH.
  - imem_req_o = 0, valid_o = 0, instr_o = 0, pc_o = 0.
- Request issue:
  - The first request is asserted in the first cycle after reset deasserts.
  - At most one request is outstanding at a time.
- States:
  - FETCH: no request outstanding. imem_req_o = (count < 2) && !redirect_i, and imem_addr_o = fetch_pc.
    - On grant: fetch_pc += 4 (wraps modulo 2^32), latch the request's PC in req_pc, go to WAIT.
    - imem_req_o and imem_addr_o must stay stable until granted.
  - WAIT: one outstanding request; imem_req_o = 0.
    - On imem_rvalid_i: push {req_pc, imem_rdata_i} into the FIFO, go to FETCH.
  - DISCARD: the outstanding response must be dropped; imem_req_o = 0.
    - On imem_rvalid_i: drop the data, go to FETCH.
- FIFO overflow cannot occur because issue requires count < 2.
- Outputs are combinational from the FIFO head: valid_o = (count != 0); instr_o and pc_o are 0 when empty.
- Pop: the head is popped at the clock edge when valid_o && !stall_i && !redirect_i.
  - Push and pop in the same cycle leaves the count unchanged.
  - A push into an empty FIFO becomes the head on the next cycle, not the same cycle.
- Redirect (redirect_i high) takes priority over every other event in that cycle:
  - FIFO cleared; fetch_pc = {redirect_pc_i[31:2], 2'b00}.
  - Next state:
    - from WAIT without rvalid that cycle → DISCARD;
    - from WAIT with rvalid that cycle → data dropped, FETCH;
    - from DISCARD without rvalid → stay in DISCARD;
    - from DISCARD with rvalid → FETCH;
    - from FETCH → FETCH (request suppressed that cycle, so no grant can occur).
  - A redirect while stall_i is high still flushes.
- Stall: stall_i only blocks the pop. Fetching continues until the FIFO is full.
- An asynchronous reset mid-transaction abandons the outstanding request. The memory side is reset by the same rst_n_i.
- Response data is never reordered; the FIFO preserves fetch order.

Test Plan:
- Reset release, RESET_PC = 0x100, memory with 1-cycle latency, gnt tied high, no stall → imem_addr_o sequence 0x100, 0x104, 0x108.
  - valid_o first high 3 cycles after reset release.
  - pc_o / instr_o then advance once per 2 cycles (one outstanding request limit).
- stall_i held high for 6 cycles from the first valid → FIFO fills with 0x100 and 0x104, then imem_req_o stays 0 and pc_o holds 0x100.
  - On release, outputs 0x100 then 0x104 on consecutive cycles.
- Redirect to 0x203 while a request to 0x108 is outstanding, with its rvalid arriving 2 cycles later:
  - FIFO empties next cycle (instr_o = 0, valid_o = 0).
  - The 0x108 data is never output.
  - The next request address is 0x200.
- Redirect in the same cycle as rvalid in WAIT → the returned word is dropped; the next cycle is in FETCH with imem_addr_o = the target.
- Grant withheld 3 cycles → imem_req_o and imem_addr_o remain stable; fetch_pc increments only on the granting cycle.
- fetch_pc = 0xFFFF_FFFC, granted → next address 0x0000_0000. Also: assert rst_n_i low while in WAIT → all outputs 0 immediately (asynchronous).
